// File: rtl/otter_bp_pkg.sv
// Shared helpers for the OTTER branch predictor: counter arithmetic,
// counter preset values, PC index/tag slicing and the entry layout.
package otter_bp_pkg;

  localparam int BP_MAX_XLEN = 64;
  localparam int BP_MAX_CTR  = 4;
  localparam int BP_MAX_TAG  = 62;

  // Entry layout at the widest legal configuration; the top keeps the
  // same fields in per-field arrays sized to its own parameters.
  typedef struct packed {
    logic                   vld;
    logic [BP_MAX_TAG-1:0]  tag;
    logic [BP_MAX_XLEN-1:0] target;
    logic [BP_MAX_CTR-1:0]  ctr;
  } btb_entry_t;

  // Saturating up/down step of a bits-wide counter held in 32 bits.
  function automatic logic [31:0] ctr_next(input logic [31:0] ctr, input logic taken,
                                           input int bits);
    logic [31:0] maxv;
    maxv = (bits >= 32) ? '1 : ((32'd1 << bits) - 32'd1);
    if (taken) return (ctr == maxv) ? ctr : ctr + 32'd1;
    else       return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

  // Weakly taken: MSB set, all other bits clear.
  function automatic logic [31:0] CTR_WEAK_T(input int bits);
    return 32'd1 << (bits - 1);
  endfunction

  // Strongly taken: all ones.
  function automatic logic [31:0] CTR_STRONG_T(input int bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  // Entry index: PC[2+idx_w-1:2].
  function automatic logic [7:0] pc_idx(input logic [BP_MAX_XLEN-1:0] pc, input int idx_w);
    return 8'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
  endfunction

  // Tag: PC[2+idx_w+tag_bits-1:2+idx_w].
  function automatic logic [BP_MAX_XLEN-1:0] pc_tag(input logic [BP_MAX_XLEN-1:0] pc,
                                                     input int idx_w, input int tag_bits);
    return (pc >> (2 + idx_w)) & ((64'd1 << tag_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/otter_btb_sat_ctr.sv
// Generic saturating counter next-state: steps up or down by one when
// enabled, clamping at zero and at all-ones.
module otter_btb_sat_ctr
  import otter_bp_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] cnt_nxt
);

  assign cnt_nxt = en ? W'(ctr_next(32'(cnt), up, W)) : cnt;

endmodule

// File: rtl/otter_btb_predictor.sv
// Direct-mapped BTB with per-entry direction counters. Fetch lookup is
// combinational off the registered arrays; decode writes resolved
// outcomes through a single update port.
module otter_btb_predictor
  import otter_bp_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8,
  parameter int XLEN     = 32,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [XLEN-1:0]   FETCH_PC,
  output logic              PRED_HIT,
  output logic              PRED_TAKEN,
  output logic [XLEN-1:0]   PRED_TARGET,
  input  logic              UPD_VALID,
  input  logic [XLEN-1:0]   UPD_PC,
  input  logic              UPD_IS_JUMP,
  input  logic              UPD_TAKEN,
  input  logic [XLEN-1:0]   UPD_TARGET,
  input  logic              UPD_MISPRED,
  input  logic              FLUSH,
  output logic [STAT_W-1:0] STAT_MISPRED
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [CTR_BITS-1:0] CTR_WEAK   = CTR_BITS'(CTR_WEAK_T(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_STRONG = CTR_BITS'(CTR_STRONG_T(CTR_BITS));

  logic [ENTRIES-1:0]  vld;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [STAT_W-1:0]   stat_q;

  logic [BP_MAX_XLEN-1:0] fpc_x, upc_x;
  logic [IDX_W-1:0]       f_idx, u_idx;
  logic [TAG_BITS-1:0]    f_tag, u_tag;
  logic                   f_hit, u_hit;
  logic [CTR_BITS-1:0]    ctr_step;
  logic [STAT_W-1:0]      stat_nxt;

  assign fpc_x = BP_MAX_XLEN'(FETCH_PC);
  assign upc_x = BP_MAX_XLEN'(UPD_PC);
  assign f_idx = IDX_W'(pc_idx(fpc_x, IDX_W));
  assign u_idx = IDX_W'(pc_idx(upc_x, IDX_W));
  assign f_tag = TAG_BITS'(pc_tag(fpc_x, IDX_W, TAG_BITS));
  assign u_tag = TAG_BITS'(pc_tag(upc_x, IDX_W, TAG_BITS));

  // Lookup sees pre-edge state only; no bypass from the update port.
  assign f_hit       = vld[f_idx] && (tag_q[f_idx] == f_tag);
  assign PRED_HIT    = f_hit;
  assign PRED_TAKEN  = f_hit && ctr_q[f_idx][CTR_BITS-1];
  assign PRED_TARGET = f_hit ? target_q[f_idx] : '0;

  assign u_hit = vld[u_idx] && (tag_q[u_idx] == u_tag);

  otter_btb_sat_ctr #(.W(CTR_BITS)) u_dir_ctr (
    .cnt     (ctr_q[u_idx]),
    .en      (1'b1),
    .up      (UPD_TAKEN),
    .cnt_nxt (ctr_step)
  );

  otter_btb_sat_ctr #(.W(STAT_W)) u_stat_ctr (
    .cnt     (stat_q),
    .en      (UPD_VALID & UPD_MISPRED),
    .up      (1'b1),
    .cnt_nxt (stat_nxt)
  );

  // Entry write port: reset/flush clear valid bits and drop the update;
  // data arrays are never reset since valid masks them.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      vld <= '0;
    end else if (UPD_VALID) begin
      if (u_hit) begin
        if (UPD_IS_JUMP) begin
          ctr_q[u_idx]    <= CTR_STRONG;
          target_q[u_idx] <= UPD_TARGET;
        end else begin
          ctr_q[u_idx] <= ctr_step;
          if (UPD_TAKEN) target_q[u_idx] <= UPD_TARGET;
        end
      end else if (UPD_TAKEN) begin
        vld[u_idx]      <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= UPD_TARGET;
        ctr_q[u_idx]    <= UPD_IS_JUMP ? CTR_STRONG : CTR_WEAK;
      end
    end
  end

  // Mispredict statistics survive flush; only reset clears them.
  always_ff @(posedge CLK) begin
    if (RST) stat_q <= '0;
    else     stat_q <= stat_nxt;
  end

  assign STAT_MISPRED = stat_q;

endmodule

// File: tb/tb_otter_btb_predictor.sv
// Directed bench: three predictor configurations driven by one shared
// stimulus stream, each with its own hand-computed expectations.
module tb_otter_btb_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] fetch_pc, upd_pc, upd_target;
  logic        upd_valid, upd_is_jump, upd_taken, upd_mispred, flush;

  logic        hit [3];
  logic        tk  [3];
  logic [31:0] tg  [3];
  logic [15:0] st  [3];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  otter_btb_predictor d0 (
    .CLK(CLK), .RST(RST), .FETCH_PC(fetch_pc),
    .PRED_HIT(hit[0]), .PRED_TAKEN(tk[0]), .PRED_TARGET(tg[0]),
    .UPD_VALID(upd_valid), .UPD_PC(upd_pc), .UPD_IS_JUMP(upd_is_jump),
    .UPD_TAKEN(upd_taken), .UPD_TARGET(upd_target), .UPD_MISPRED(upd_mispred),
    .FLUSH(flush), .STAT_MISPRED(st[0])
  );

  otter_btb_predictor #(.ENTRIES(4), .CTR_BITS(1)) d1 (
    .CLK(CLK), .RST(RST), .FETCH_PC(fetch_pc),
    .PRED_HIT(hit[1]), .PRED_TAKEN(tk[1]), .PRED_TARGET(tg[1]),
    .UPD_VALID(upd_valid), .UPD_PC(upd_pc), .UPD_IS_JUMP(upd_is_jump),
    .UPD_TAKEN(upd_taken), .UPD_TARGET(upd_target), .UPD_MISPRED(upd_mispred),
    .FLUSH(flush), .STAT_MISPRED(st[1])
  );

  otter_btb_predictor #(.ENTRIES(64), .CTR_BITS(3)) d2 (
    .CLK(CLK), .RST(RST), .FETCH_PC(fetch_pc),
    .PRED_HIT(hit[2]), .PRED_TAKEN(tk[2]), .PRED_TARGET(tg[2]),
    .UPD_VALID(upd_valid), .UPD_PC(upd_pc), .UPD_IS_JUMP(upd_is_jump),
    .UPD_TAKEN(upd_taken), .UPD_TARGET(upd_target), .UPD_MISPRED(upd_mispred),
    .FLUSH(flush), .STAT_MISPRED(st[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // eh/et bit i is the expectation for DUT i.
  task automatic look3(input string tag, input logic [31:0] pc, input logic [2:0] eh,
                       input logic [2:0] et, input logic [31:0] g0, input logic [31:0] g1,
                       input logic [31:0] g2);
    logic [31:0] eg [3];
    eg = '{g0, g1, g2};
    fetch_pc = pc;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.hit%0d", tag, i), 32'(hit[i]), 32'(eh[i]));
      chk($sformatf("%s.taken%0d", tag, i), 32'(tk[i]), 32'(et[i]));
      chk($sformatf("%s.target%0d", tag, i), tg[i], eg[i]);
    end
  endtask

  task automatic chk_stat(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s.stat%0d", tag, i), 32'(st[i]), 32'(exp));
  endtask

  task automatic upd(input logic [31:0] pc, input logic jump, input logic taken,
                     input logic [31:0] tgt);
    @(negedge CLK);
    upd_valid = 1'b1; upd_pc = pc; upd_is_jump = jump;
    upd_taken = taken; upd_target = tgt; upd_mispred = 1'b0;
    @(posedge CLK);
    #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    // Reset with an update and a mispredict pending; both must be dropped.
    RST = 1'b1; flush = 1'b0; fetch_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_is_jump = 1'b0; upd_taken = 1'b1;
    upd_target = 32'h40; upd_mispred = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
    look3("rst", 32'h100, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    chk_stat("rst", 16'h0);

    // Branch allocation and training at 0x100.
    upd(32'h100, 1'b0, 1'b1, 32'h40);
    look3("alloc", 32'h100, 3'b111, 3'b111, 32'h40, 32'h40, 32'h40);
    upd(32'h100, 1'b0, 1'b0, 32'h0);
    look3("nt1", 32'h100, 3'b111, 3'b000, 32'h40, 32'h40, 32'h40);
    upd(32'h100, 1'b0, 1'b0, 32'h0);
    look3("nt2", 32'h100, 3'b111, 3'b000, 32'h40, 32'h40, 32'h40);
    upd(32'h100, 1'b0, 1'b1, 32'h48);
    look3("t1", 32'h100, 3'b111, 3'b010, 32'h48, 32'h48, 32'h48);
    upd(32'h100, 1'b0, 1'b1, 32'h48);
    look3("t2", 32'h100, 3'b111, 3'b111, 32'h48, 32'h48, 32'h48);
    upd(32'h100, 1'b0, 1'b1, 32'h48);
    look3("t3", 32'h100, 3'b111, 3'b111, 32'h48, 32'h48, 32'h48);
    upd(32'h100, 1'b0, 1'b0, 32'h0);
    look3("sat_nt1", 32'h100, 3'b111, 3'b101, 32'h48, 32'h48, 32'h48);
    upd(32'h100, 1'b0, 1'b0, 32'h0);
    look3("sat_nt2", 32'h100, 3'b111, 3'b000, 32'h48, 32'h48, 32'h48);

    // Not-taken miss allocates nothing.
    upd(32'h108, 1'b0, 1'b0, 32'h77);
    look3("miss_nt", 32'h108, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0);

    // Jump allocation, then one not-taken branch update.
    upd(32'h104, 1'b1, 1'b1, 32'h200);
    look3("jump", 32'h104, 3'b111, 3'b111, 32'h200, 32'h200, 32'h200);
    upd(32'h104, 1'b0, 1'b0, 32'h999);
    look3("jump_nt", 32'h104, 3'b111, 3'b101, 32'h200, 32'h200, 32'h200);

    // 0x144 aliases 0x104 in the 16- and 4-entry configs, not in 64.
    upd(32'h144, 1'b0, 1'b1, 32'h300);
    look3("alias_old", 32'h104, 3'b100, 3'b100, 32'h0, 32'h0, 32'h200);
    look3("alias_new", 32'h144, 3'b111, 3'b111, 32'h300, 32'h300, 32'h300);

    // Same-cycle update and lookup: old state before the edge, new after.
    @(negedge CLK);
    upd_valid = 1'b1; upd_pc = 32'h144; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_target = 32'h0;
    look3("same_old", 32'h144, 3'b111, 3'b111, 32'h300, 32'h300, 32'h300);
    @(posedge CLK);
    #1;
    upd_valid = 1'b0;
    look3("same_new", 32'h144, 3'b111, 3'b000, 32'h300, 32'h300, 32'h300);

    // Flush beats a simultaneous update.
    @(negedge CLK);
    flush = 1'b1; upd_valid = 1'b1; upd_pc = 32'h10C; upd_is_jump = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h500;
    @(posedge CLK);
    #1;
    flush = 1'b0; upd_valid = 1'b0;
    look3("flush100", 32'h100, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    look3("flush104", 32'h104, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    look3("flush144", 32'h144, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    look3("flush10c", 32'h10C, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    chk_stat("stat_pre", 16'h0);

    // Mispredict without UPD_VALID is ignored.
    upd_mispred = 1'b1;
    @(posedge CLK);
    #1;
    chk_stat("stat_unq", 16'h0);

    // Qualified mispredicts on a not-taken miss (entries untouched).
    upd_valid = 1'b1; upd_pc = 32'h108; upd_is_jump = 1'b0; upd_taken = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_stat("stat3", 16'h3);
    repeat (32'hFFFE - 3) @(posedge CLK);
    #1;
    chk_stat("stat_fffe", 16'hFFFE);
    @(posedge CLK);
    #1;
    chk_stat("stat_ffff", 16'hFFFF);
    repeat (2) @(posedge CLK);
    #1;
    chk_stat("stat_sat", 16'hFFFF);
    upd_valid = 1'b0; upd_mispred = 1'b0;

    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    chk_stat("stat_flush", 16'hFFFF);

    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_stat("stat_rst", 16'h0);
    look3("rst2", 32'h100, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otter_btb_predictor.md
Name: otter_btb_predictor

Overview:
Parametrised branch target buffer with per-entry saturating direction counters for the pipelined OTTER core. Fetch presents the current PC and receives a same-cycle taken/target prediction that drives the PC mux. Decode resolves branches and jumps and writes the outcomes back through the update port. The block replaces the fixed always-not-taken fetch plus clear-on-branch scheme with learned redirection.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, 2..256; IDX_W = log2(ENTRIES)
TAG_BITS, 8, tag width taken from PC[2+IDX_W+TAG_BITS-1 : 2+IDX_W]; 2+IDX_W+TAG_BITS <= XLEN
XLEN, 32, PC and target width
CTR_BITS, 2, direction counter width, 1..4; predict taken when counter MSB = 1
STAT_W, 16, width of the saturating mispredict statistics counter

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
FETCH_PC  in  XLEN  PC currently being fetched
PRED_HIT  out  1  valid entry whose tag matches FETCH_PC
PRED_TAKEN  out  1  PRED_HIT and counter MSB = 1
PRED_TARGET  out  XLEN  stored target; 0 when PRED_HIT = 0
UPD_VALID  in  1  decode resolved a control-flow instruction this cycle
UPD_PC  in  XLEN  PC of the resolved instruction
UPD_IS_JUMP  in  1  1 = JAL/JALR (unconditional); 0 = conditional branch
UPD_TAKEN  in  1  actual direction
UPD_TARGET  in  XLEN  actual target (meaningful only when UPD_TAKEN = 1)
UPD_MISPRED  in  1  decode detected a wrong prediction; qualified by UPD_VALID
FLUSH  in  1  invalidate all entries (fence.i / reprogramming)
STAT_MISPRED  out  STAT_W  count of qualified mispredicts, saturating at all-ones

Behaviour:
- Storage per entry: valid bit, TAG_BITS tag, XLEN target, CTR_BITS counter.
- Entry index = PC[2+IDX_W-1:2]. PC[1:0] is ignored.
- Lookup is purely combinational from FETCH_PC, with zero latency. It reads the register state from before the clock edge. There is no write-to-read bypass: an update at edge N becomes visible to lookups from cycle N+1 onward.
- Update is applied on the rising edge when UPD_VALID = 1, RST = 0 and FLUSH = 0.
  - Hit (valid and tag match), branch: counter +1 if taken, -1 if not taken, saturating at 0 and at 2^CTR_BITS-1. If taken, the target is overwritten with UPD_TARGET.
  - Hit, jump: counter is set to all-ones and the target is overwritten.
  - Miss and taken: allocate the entry, overwriting any prior occupant. Set valid = 1, write tag and target. Counter = all-ones for a jump; for a branch, counter = 1 followed by CTR_BITS-1 zeros (weakly taken).
  - Miss and not taken: no change to the entry.
- STAT_MISPRED increments by 1 on any edge where UPD_VALID & UPD_MISPRED, and holds at 2^STAT_W-1 once saturated. FLUSH does not clear it.
- FLUSH = 1: all valid bits are cleared at the edge. If FLUSH and UPD_VALID occur in the same cycle, FLUSH wins and the update is dropped.
- RST = 1: all valid bits and STAT_MISPRED are cleared at the edge, and any update in that cycle is dropped.
  - Outputs after reset: PRED_HIT = 0, PRED_TAKEN = 0, PRED_TARGET = 0, STAT_MISPRED = 0.
  - Tag, target and counter arrays are not reset; valid = 0 masks them.
- Aliasing is not an error: a different tag at the same index is simply a miss and is replaced on the next taken allocation.
- No internal FSM. Sequential state is the entry arrays plus the statistics counter. Single write port, single read port.

Decomposition:
- Package otter_bp_pkg holds:
  - function ctr_next(ctr, taken) giving saturating up/down behaviour;
  - CTR_WEAK_T and CTR_STRONG_T constant functions of CTR_BITS;
  - the index/tag slicing functions;
  - typedef btb_entry_t.
- One sub-module, otter_btb_sat_ctr, provides the generic saturating counter. It is reused for the direction counters' next-state logic and for STAT_MISPRED.

Test Plan:
1. Reset and lookup. RST for 1 cycle, then FETCH_PC = 0x100 -> PRED_HIT = 0, PRED_TAKEN = 0, PRED_TARGET = 0, STAT_MISPRED = 0.
2. Allocate and train a branch.
   - Update at PC 0x100, branch, taken, target 0x40, then lookup 0x100 -> HIT = 1, TAKEN = 1 (counter 2'b10), TARGET = 0x40.
   - Two not-taken updates -> counter 2'b00, TAKEN = 0, HIT = 1.
   - Three more taken updates -> counter saturates at 2'b11.
3. Jump and alias.
   - Jump update at 0x104, target 0x200 -> counter 2'b11. One not-taken branch update at 0x104 -> still TAKEN (counter 2'b10).
   - With ENTRIES = 16, TAG_BITS = 8: taken update at 0x144 (same index, different tag) -> lookup at 0x104 misses, lookup at 0x144 hits.
4. Timing and priority.
   - Update and lookup of the same PC in the same cycle -> prediction reflects the old state; the new state appears the next cycle.
   - FLUSH asserted with UPD_VALID -> all lookups miss afterwards and the update is lost.
5. Statistics. Drive 0xFFFF+3 qualified mispredicts with STAT_W = 16 -> STAT_MISPRED = 0xFFFF. UPD_MISPRED with UPD_VALID = 0 -> no increment. RST -> 0.
6. Parameter sweep. Repeat scenarios 2–3 with ENTRIES = 4, CTR_BITS = 1 and ENTRIES = 64, CTR_BITS = 3. Allocation counter values must be 1'b1 and 3'b100 respectively.
